sample_iter: RTL and testbench

SAMPLE_ITER -- requirements
Module: sample_iter

---
 rtl/rast_pkg.sv | 24 ++
 rtl/dff.sv | 62 ++++++
 rtl/sample_step.sv | 44 ++++
 rtl/sample_iter.sv | 169 ++++++++++++++++
 tb/tb_sample_iter.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/rast_pkg.sv
// Shared rasterizer definitions: default word geometry, iterator state encoding
// and the subsample-mode decode used by the sample iterator.
package rast_pkg;

    localparam int DEF_SIGFIG = 24;
    localparam int DEF_RADIX  = 10;
    localparam int DEF_VERTS  = 3;
    localparam int DEF_AXIS   = 3;
    localparam int DEF_COLORS = 3;

    typedef enum logic {
        WAIT = 1'b0,
        TEST = 1'b1
    } state_t;

    // One-hot subsample mode to log2 of samples per pixel edge; lowest set bit wins.
    function automatic int ss_w_lg2(input logic [3:0] mode);
        if (mode[0]) return 3;
        if (mode[1]) return 2;
        if (mode[2]) return 1;
        return 0;
    endfunction

endpackage

// File: rtl/dff.sv
// Library register cells: enabled flops with asynchronous active-high reset,
// in scalar-word, 1-D array and 2-D array shapes.
module dff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= RST_VAL;
        else if (en)
            q <= d;
    end

endmodule

module dff2 #(
    parameter int WIDTH = 1,
    parameter int DIM1  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [DIM1-1:0][WIDTH-1:0] d,
    output logic [DIM1-1:0][WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

module dff3 #(
    parameter int WIDTH = 1,
    parameter int DIM1  = 1,
    parameter int DIM2  = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 en,
    input  logic [DIM1-1:0][DIM2-1:0][WIDTH-1:0] d,
    output logic [DIM1-1:0][DIM2-1:0][WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/sample_step.sv
// Combinational next-sample generator: advance along x, wrap to the next row,
// or flag the last sample of the bounding box.
module sample_step
    import rast_pkg::*;
#(
    parameter int SIGFIG = DEF_SIGFIG
) (
    input  logic signed [SIGFIG-1:0] cur_x,
    input  logic signed [SIGFIG-1:0] cur_y,
    input  logic signed [SIGFIG-1:0] ll_x,
    input  logic signed [SIGFIG-1:0] ur_x,
    input  logic signed [SIGFIG-1:0] ur_y,
    input  logic signed [SIGFIG-1:0] step,
    output logic signed [SIGFIG-1:0] next_x,
    output logic signed [SIGFIG-1:0] next_y,
    output logic                     last
);

    // One guard bit keeps x+step from wrapping negative near the top of the range.
    logic signed [SIGFIG:0] x_adv;
    logic signed [SIGFIG:0] y_adv;
    logic signed [SIGFIG:0] ur_x_ext;
    logic signed [SIGFIG:0] ur_y_ext;

    assign x_adv    = {cur_x[SIGFIG-1], cur_x} + {step[SIGFIG-1], step};
    assign y_adv    = {cur_y[SIGFIG-1], cur_y} + {step[SIGFIG-1], step};
    assign ur_x_ext = {ur_x[SIGFIG-1], ur_x};
    assign ur_y_ext = {ur_y[SIGFIG-1], ur_y};

    always_comb begin
        next_x = cur_x;
        next_y = cur_y;
        last   = 1'b0;
        if (x_adv <= ur_x_ext) begin
            next_x = x_adv[SIGFIG-1:0];
        end else if (y_adv <= ur_y_ext) begin
            next_x = ll_x;
            next_y = y_adv[SIGFIG-1:0];
        end else begin
            last = 1'b1;
        end
    end

endmodule

// File: rtl/sample_iter.sv
// Sample iterator: accepts one triangle with its bounding box and walks the
// subsample grid row-major from lower-left, stalling upstream while busy.
module sample_iter
    import rast_pkg::*;
#(
    parameter int SIGFIG = DEF_SIGFIG,
    parameter int RADIX  = DEF_RADIX,
    parameter int VERTS  = DEF_VERTS,
    parameter int AXIS   = DEF_AXIS,
    parameter int COLORS = DEF_COLORS
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S,
    input  logic        [COLORS-1:0][SIGFIG-1:0]        color_R13U,
    input  logic                                        validTri_R13H,
    input  logic signed [1:0][1:0][SIGFIG-1:0]          box_R13S,
    input  logic        [3:0]                           subSample_RnnnnU,
    output logic                                        halt_RnnnnL,
    output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S,
    output logic        [COLORS-1:0][SIGFIG-1:0]        color_R14U,
    output logic signed [1:0][SIGFIG-1:0]               sample_R14S,
    output logic                                        validSamp_R14H
);

    state_t state;
    state_t next_state;

    logic                        accept;
    logic                        sample_en;
    logic signed [1:0][SIGFIG-1:0] sample_d;
    logic                        valid_d;
    logic                        halt_d;

    // Latched box corners used for iteration: [0]=ll_x, [1]=ur_x, [2]=ur_y.
    logic [2:0][SIGFIG-1:0] bounds_d;
    logic [2:0][SIGFIG-1:0] bounds_q;

    logic signed [SIGFIG-1:0] step;
    logic signed [SIGFIG-1:0] next_x;
    logic signed [SIGFIG-1:0] next_y;
    logic                     last;

    assign step = {{(SIGFIG-1){1'b0}}, 1'b1} << (RADIX - ss_w_lg2(subSample_RnnnnU));

    assign bounds_d = {box_R13S[1][1], box_R13S[1][0], box_R13S[0][0]};

    sample_step #(
        .SIGFIG (SIGFIG)
    ) u_step (
        .cur_x  (sample_R14S[0]),
        .cur_y  (sample_R14S[1]),
        .ll_x   (bounds_q[0]),
        .ur_x   (bounds_q[1]),
        .ur_y   (bounds_q[2]),
        .step   (step),
        .next_x (next_x),
        .next_y (next_y),
        .last   (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= WAIT;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        sample_en  = 1'b0;
        sample_d   = sample_R14S;
        valid_d    = 1'b0;
        case (state)
            WAIT: begin
                if (validTri_R13H) begin
                    accept      = 1'b1;
                    sample_en   = 1'b1;
                    sample_d[0] = box_R13S[0][0];
                    sample_d[1] = box_R13S[0][1];
                    valid_d     = 1'b1;
                    next_state  = TEST;
                end
            end
            TEST: begin
                if (last) begin
                    next_state = WAIT;
                end else begin
                    sample_en   = 1'b1;
                    sample_d[0] = next_x;
                    sample_d[1] = next_y;
                    valid_d     = 1'b1;
                end
            end
            default: next_state = WAIT;
        endcase
    end

    // Stall is registered off the next state so it is low exactly while in TEST.
    assign halt_d = (next_state != TEST);

    dff #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_halt (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .d   (halt_d),
        .q   (halt_RnnnnL)
    );

    dff #(
        .WIDTH (1)
    ) u_valid (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .d   (valid_d),
        .q   (validSamp_R14H)
    );

    dff2 #(
        .WIDTH (SIGFIG),
        .DIM1  (2)
    ) u_sample (
        .clk (clk),
        .rst (rst),
        .en  (sample_en),
        .d   (sample_d),
        .q   (sample_R14S)
    );

    dff2 #(
        .WIDTH (SIGFIG),
        .DIM1  (3)
    ) u_bounds (
        .clk (clk),
        .rst (rst),
        .en  (accept),
        .d   (bounds_d),
        .q   (bounds_q)
    );

    dff3 #(
        .WIDTH (SIGFIG),
        .DIM1  (VERTS),
        .DIM2  (AXIS)
    ) u_tri (
        .clk (clk),
        .rst (rst),
        .en  (accept),
        .d   (tri_R13S),
        .q   (tri_R14S)
    );

    dff2 #(
        .WIDTH (SIGFIG),
        .DIM1  (COLORS)
    ) u_color (
        .clk (clk),
        .rst (rst),
        .en  (accept),
        .d   (color_R13U),
        .q   (color_R14U)
    );

endmodule

// File: tb/tb_sample_iter.sv
// Directed bench for sample_iter: grid walks, degenerate box, back-to-back
// triangles, mid-triangle reset and near-overflow bounds.
module tb_sample_iter;

    logic clk = 1'b0;
    logic rst;
    logic signed [2:0][2:0][23:0] tri_in;
    logic        [2:0][23:0]      color_in;
    logic                         valid_tri;
    logic signed [1:0][1:0][23:0] box_in;
    logic        [3:0]            sub_sample;
    logic                         halt;
    logic signed [2:0][2:0][23:0] tri_out;
    logic        [2:0][23:0]      color_out;
    logic signed [1:0][23:0]      sample;
    logic                         valid_samp;

    logic signed [2:0][2:0][23:0] exp_tri;
    logic        [2:0][23:0]      exp_color;
    logic [23:0] exp_x[$];
    logic [23:0] exp_y[$];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sample_iter dut (
        .clk              (clk),
        .rst              (rst),
        .tri_R13S         (tri_in),
        .color_R13U       (color_in),
        .validTri_R13H    (valid_tri),
        .box_R13S         (box_in),
        .subSample_RnnnnU (sub_sample),
        .halt_RnnnnL      (halt),
        .tri_R14S         (tri_out),
        .color_R14U       (color_out),
        .sample_R14S      (sample),
        .validSamp_R14H   (valid_samp)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [215:0] mk_tri(input int k);
        logic [215:0] r;
        for (int i = 0; i < 9; i++) r[i*24 +: 24] = 24'(k * 4096 + i * 17 - 50);
        return r;
    endfunction

    function automatic logic [71:0] mk_col(input int k);
        logic [71:0] r;
        for (int i = 0; i < 3; i++) r[i*24 +: 24] = 24'(k * 1000 + i * 255 + 7);
        return r;
    endfunction

    task automatic add_exp(input int x, input int y);
        exp_x.push_back(24'(x));
        exp_y.push_back(24'(y));
    endtask

    task automatic load_tri(input int k, input int llx, input int lly,
                            input int urx, input int ury);
        tri_in       = mk_tri(k);
        color_in     = mk_col(k);
        box_in[0][0] = 24'(llx);
        box_in[0][1] = 24'(lly);
        box_in[1][0] = 24'(urx);
        box_in[1][1] = 24'(ury);
        exp_tri      = mk_tri(k);
        exp_color    = mk_col(k);
    endtask

    // Presents a triangle while idle and returns just after the accepting edge.
    task automatic start_tri(input int k, input int llx, input int lly,
                             input int urx, input int ury, input logic [3:0] ss,
                             input bit hold);
        @(negedge clk);
        chk($sformatf("idle halt t%0d", k), halt, 1'b1);
        load_tri(k, llx, lly, urx, ury);
        sub_sample = ss;
        valid_tri  = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) valid_tri = 1'b0;
    endtask

    task automatic collect(input string tag, input int n, input bit check_end);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk($sformatf("%s vld%0d", tag, i), valid_samp, 1'b1);
            chk($sformatf("%s halt%0d", tag, i), halt, 1'b0);
            chk($sformatf("%s x%0d", tag, i), sample[0], exp_x[i]);
            chk($sformatf("%s y%0d", tag, i), sample[1], exp_y[i]);
            chk($sformatf("%s tri%0d", tag, i), tri_out, exp_tri);
            chk($sformatf("%s col%0d", tag, i), color_out, exp_color);
        end
        if (check_end) begin
            @(negedge clk);
            chk($sformatf("%s end vld", tag), valid_samp, 1'b0);
            chk($sformatf("%s end halt", tag), halt, 1'b1);
        end
    endtask

    initial begin
        rst        = 1'b1;
        valid_tri  = 1'b0;
        tri_in     = '0;
        color_in   = '0;
        box_in     = '0;
        sub_sample = 4'b1000;

        repeat (2) @(negedge clk);
        chk("rst vld", valid_samp, 1'b0);
        chk("rst halt", halt, 1'b1);
        chk("rst sample", sample, 48'h0);
        chk("rst tri", tri_out, 216'h0);
        chk("rst col", color_out, 72'h0);
        rst = 1'b0;

        // 3x2 grid, step 1024
        start_tri(1, 0, 0, 2048, 1024, 4'b1000, 1'b0);
        exp_x.delete(); exp_y.delete();
        add_exp(0, 0);    add_exp(1024, 0);    add_exp(2048, 0);
        add_exp(0, 1024); add_exp(1024, 1024); add_exp(2048, 1024);
        collect("grid", 6, 1'b1);

        // degenerate box, step 256
        start_tri(2, 512, 512, 512, 512, 4'b0010, 1'b0);
        exp_x.delete(); exp_y.delete();
        add_exp(512, 512);
        collect("degen", 1, 1'b1);

        // ur_x not on the grid, step 128
        start_tri(3, 0, 0, 300, 128, 4'b0001, 1'b0);
        exp_x.delete(); exp_y.delete();
        add_exp(0, 0);   add_exp(128, 0);   add_exp(256, 0);
        add_exp(0, 128); add_exp(128, 128); add_exp(256, 128);
        collect("ragged", 6, 1'b1);

        // back-to-back: triangle 2 waits with valid high during triangle 1
        start_tri(4, -256, -256, 0, 0, 4'b0010, 1'b1);
        tri_in       = mk_tri(5);
        color_in     = mk_col(5);
        box_in[0][0] = 24'(100);
        box_in[0][1] = 24'(50);
        box_in[1][0] = 24'(356);
        box_in[1][1] = 24'(50);
        exp_x.delete(); exp_y.delete();
        add_exp(-256, -256); add_exp(0, -256); add_exp(-256, 0); add_exp(0, 0);
        collect("b2b1", 4, 1'b1);
        @(posedge clk);
        #1;
        valid_tri = 1'b0;
        exp_tri   = mk_tri(5);
        exp_color = mk_col(5);
        exp_x.delete(); exp_y.delete();
        add_exp(100, 50); add_exp(356, 50);
        collect("b2b2", 2, 1'b1);

        // reset after the third of six samples
        start_tri(6, 0, 0, 2048, 1024, 4'b1000, 1'b0);
        exp_x.delete(); exp_y.delete();
        add_exp(0, 0); add_exp(1024, 0); add_exp(2048, 0);
        collect("mrst", 3, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("mrst vld", valid_samp, 1'b0);
        chk("mrst halt", halt, 1'b1);
        chk("mrst sample", sample, 48'h0);
        chk("mrst tri", tri_out, 216'h0);
        chk("mrst col", color_out, 72'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("post rst vld%0d", i), valid_samp, 1'b0);
            chk($sformatf("post rst halt%0d", i), halt, 1'b1);
        end

        // ur_x at the most positive 24-bit value: x+step must not wrap
        start_tri(7, 8387583, 0, 8388607, 0, 4'b1000, 1'b0);
        exp_x.delete(); exp_y.delete();
        add_exp(8387583, 0); add_exp(8388607, 0);
        collect("ovf", 2, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
